// File: rtl/jtag_shift_ctrl.sv
// JTAG master: replays a TAP reset/idle sequence after reset, then runs IR scans,
// DR scans and TAP resets one command at a time, returning captured TDO bits.
module jtag_shift_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        tgt_tck,
  output logic        tgt_tms,
  output logic        tgt_tdi,
  output logic        tgt_trstb,
  input  logic        tgt_tdo
);

  typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RESP} state_t;

  localparam logic [1:0] OP_DR  = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_RST = 2'b10;
  localparam logic [8:0] CNT_MAX  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] CNT_RISE = 9'(CLK_DIV - 1);

  state_t      state, nxt_state;
  logic [4:0]  pidx, nxt_pidx, last_idx;
  logic [8:0]  cnt;
  logic        launch, running, boundary, rise, accept;
  logic        nxt_tms, nxt_tdi;
  logic [1:0]  op_q;
  logic [4:0]  len_q;
  logic [31:0] data_q;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state == INIT) || (state == PRE) || (state == SHIFT) || (state == POST);
  // cnt counts clk cycles since the edge that opened the current TCK low phase
  assign boundary  = running && (cnt == CNT_MAX);
  assign rise      = running && (cnt == CNT_RISE);

  always_comb begin
    last_idx = 5'd0;
    case (state)
      INIT:    last_idx = 5'd5;
      PRE:     last_idx = (op_q == OP_IR) ? 5'd3 : ((op_q == OP_DR) ? 5'd2 : 5'd4);
      SHIFT:   last_idx = len_q;
      POST:    last_idx = (op_q == OP_RST) ? 5'd0 : 5'd1;
      default: last_idx = 5'd0;
    endcase
  end

  // launch marks a boundary that opens period 0 of the current state instead of advancing
  always_comb begin
    nxt_state = state;
    nxt_pidx  = pidx;
    if (accept) begin
      nxt_state = PRE;
      nxt_pidx  = 5'd0;
    end else if (rsp_valid && rsp_ready) begin
      nxt_state = IDLE;
    end else if (boundary && !launch) begin
      if (pidx == last_idx) begin
        nxt_pidx = 5'd0;
        case (state)
          INIT:    nxt_state = IDLE;
          PRE:     nxt_state = (op_q == OP_RST) ? POST : SHIFT;
          SHIFT:   nxt_state = POST;
          POST:    nxt_state = RESP;
          default: nxt_state = state;
        endcase
      end else begin
        nxt_pidx = pidx + 5'd1;
      end
    end
  end

  always_comb begin
    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    case (nxt_state)
      INIT: nxt_tms = (nxt_pidx != 5'd5);
      PRE: begin
        if (op_q == OP_IR)      nxt_tms = (nxt_pidx < 5'd2);
        else if (op_q == OP_DR) nxt_tms = (nxt_pidx == 5'd0);
        else                    nxt_tms = 1'b1;
      end
      SHIFT: begin
        nxt_tms = (nxt_pidx == len_q);
        nxt_tdi = data_q[nxt_pidx];
      end
      POST:    nxt_tms = (op_q != OP_RST) && (nxt_pidx == 5'd0);
      default: nxt_tms = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state <= INIT;
      pidx  <= 5'd0;
    end else begin
      state <= nxt_state;
      pidx  <= nxt_pidx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt       <= CNT_MAX;
      launch    <= 1'b1;
      tgt_tck   <= 1'b0;
      tgt_tms   <= 1'b1;
      tgt_tdi   <= 1'b0;
      tgt_trstb <= 1'b0;
      op_q      <= OP_DR;
      len_q     <= 5'd0;
      data_q    <= 32'd0;
      rsp_data  <= 32'd0;
    end else begin
      tgt_trstb <= 1'b1;
      if (accept) begin
        op_q     <= cmd_op[1] ? OP_RST : cmd_op;
        len_q    <= cmd_len;
        data_q   <= cmd_data;
        rsp_data <= 32'd0;
        cnt      <= CNT_MAX;
        launch   <= 1'b1;
      end
      if (boundary) begin
        cnt     <= 9'd0;
        launch  <= 1'b0;
        tgt_tck <= 1'b0;
        tgt_tms <= nxt_tms;
        tgt_tdi <= nxt_tdi;
      end else if (running) begin
        cnt <= cnt + 9'd1;
      end
      if (rise) begin
        tgt_tck <= 1'b1;
        if (state == SHIFT) rsp_data[pidx] <= tgt_tdo;
      end
    end
  end

endmodule

// File: doc/jtag_shift_ctrl.md
JTAG_SHIFT_CTRL -- requirements
Module: jtag_shift_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, range 1..255: TCK half-period in CLK cycles.
REQ-002 CLK  in  1  system clock; all logic on rising edge.
REQ-003 RSTB  in  1  reset; one clock, reset is synchronous and active-low.
REQ-004 CMD_VALID  in  1  command request.
REQ-005 CMD_READY  out  1  command accept; transfer on CMD_VALID&CMD_READY at rising CLK.
REQ-006 CMD_OP  in  2  00 DR scan, 01 IR scan, 10 TAP reset, 11 treated as 10.
REQ-007 CMD_LEN  in  5  scan bit count minus one (N = CMD_LEN+1, 1..32).
REQ-008 CMD_DATA  in  32  TDI bits, LSB shifted first.
REQ-009 RSP_VALID  out  1  response available.
REQ-010 RSP_READY  in  1  response consumed on RSP_VALID&RSP_READY.
REQ-011 RSP_DATA  out  32  captured TDO bits, bit i = i-th shifted bit, bits >= N zero.
REQ-012 TGT_TCK, TGT_TMS, TGT_TDI, TGT_TRSTB  out  1 each  target JTAG drive.
REQ-013 TGT_TDO  in  1  target TDO.

Function
REQ-014 TCK period SHALL be 2*CLK_DIV CLK cycles: low phase CLK_DIV, then high phase CLK_DIV; TGT_TCK idles low between periods.
REQ-015 TGT_TMS/TGT_TDI SHALL change only on the CLK edge that starts a low phase; TGT_TDO SHALL be sampled on the CLK edge where TGT_TCK goes 0->1.
REQ-016 States: INIT, IDLE, PRE, SHIFT, POST, RESP.
REQ-017 INIT: 5 TCK periods TMS=1, then 1 period TMS=0 (Run-Test/Idle), then IDLE; entered after reset.
REQ-018 IDLE: CMD_READY=1 only here; TGT_TCK=0, TMS=0; accept moves to PRE next cycle.
REQ-019 PRE TMS sequence: IR 1,1,0,0; DR 1,0,0; TAP reset 1,1,1,1,1 then POST directly.
REQ-020 SHIFT: N periods, TDI=CMD_DATA[i] in period i, TMS=0 except last period TMS=1; TDO sampled into RSP_DATA bit i.
REQ-021 POST: scans 1 then 0 (Update, Idle); TAP reset a single 0 period.
REQ-022 Total TCK periods T: IR N+6, DR N+5, TAP reset 6.
REQ-023 RSP_VALID SHALL rise exactly 2*CLK_DIV*T+1 CLK cycles after the accept edge; TAP reset gives RSP_DATA=0.
REQ-024 RESP: RSP_VALID, RSP_DATA held stable until RSP_READY; handshake returns to IDLE next cycle; RSP_READY while RSP_VALID=0 ignored.
REQ-025 CMD_DATA, CMD_OP, CMD_LEN SHALL be registered at accept; later input changes do not affect an in-flight scan.
REQ-026 CMD_VALID outside IDLE SHALL be ignored (no accept, no queueing).

Reset
REQ-027 While RSTB=0 at a CLK edge: TGT_TCK=0, TGT_TMS=1, TGT_TDI=0, TGT_TRSTB=0, CMD_READY=0, RSP_VALID=0, RSP_DATA=0, state INIT.
REQ-028 TGT_TRSTB SHALL go 1 on the first edge with RSTB=1; INIT sequence starts same edge.
REQ-029 RSTB low mid-scan or with a pending response SHALL drop the command and response with no RSP_VALID, then replay INIT.

Verification
REQ-030 Reset release, CLK_DIV=2 -> TGT_TRSTB=1 next edge; 5 TMS=1 + 1 TMS=0 periods; CMD_READY=1 after 24 CLK cycles.
REQ-031 DR scan CMD_LEN=7, CMD_DATA=0xA5, target model loops TDI to TDO with 1-bit capture 0 -> TDI sequence 1,0,1,0,0,1,0,1; RSP_VALID after 53 cycles; RSP_DATA=0x4A (capture bit then data shifted).
REQ-032 IR scan CMD_LEN=7, CMD_DATA=0x55 against tap model with IR capture 0x01 -> TMS 1,1,0,0,0x7,1,1,0; RSP_DATA=0x01; model IR=0x55.
REQ-033 CMD_LEN=31, DR, CMD_DATA=0xFFFFFFFF, TDO tied 1 -> RSP_DATA=0xFFFFFFFF; CMD_LEN=0 -> single-period shift with TMS=1, RSP_DATA bit0 only.
REQ-034 RSP_READY held 0 for 100 cycles -> RSP_VALID/RSP_DATA stable, CMD_READY=0, CMD_VALID ignored; then handshake -> CMD_READY=1 next cycle.
REQ-035 RSTB pulsed low during SHIFT period 3 -> outputs at reset values next edge, no RSP_VALID, INIT replayed, next command scans correctly.
